// File: rtl/ibuf_pe_row_aligner.sv
// Input-buffer to PE row aligner: latency-matched, rotation-aware bank-to-lane
// mux between ping-pong SRAM buffers and the PE column inputs.

module ibuf_pe_lane_sel #(
  parameter int WORD_SIZE = 16,
  parameter int N_BANKS   = 3,
  parameter int BANK_W    = 2,
  parameter int LANE      = 0
) (
  input  logic [N_BANKS*WORD_SIZE-1:0] q_i,
  input  logic [BANK_W-1:0]            rot_i,
  output logic [WORD_SIZE-1:0]         word_o
);
  localparam logic [BANK_W:0] NB = (BANK_W+1)'(N_BANKS);
  localparam logic [BANK_W:0] LN = (BANK_W+1)'(LANE);

  logic [BANK_W:0] sum, idx;

  // rot and LANE are both < N_BANKS, so one conditional subtract is a full mod.
  assign sum = {1'b0, rot_i} + LN;
  assign idx = (sum >= NB) ? sum - NB : sum;

  always_comb begin
    word_o = '0;
    for (int k = 0; k < N_BANKS; k++)
      if (idx == (BANK_W+1)'(k)) word_o = q_i[k*WORD_SIZE +: WORD_SIZE];
  end
endmodule

module ibuf_pe_row_aligner #(
  parameter int WORD_SIZE  = 16,
  parameter int N_BANKS    = 3,
  parameter int BANK_W     = 2,
  parameter int ADDR_SIZE  = 13,
  parameter int BS_W       = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [BANK_W-1:0]            start_bank,
  input  logic [1:0]                   kernel_size,
  input  logic                         row_adv,
  input  logic                         rd_en,
  input  logic                         buf_sel,
  input  logic [ADDR_SIZE-1:0]         rd_addr,
  input  logic [ADDR_SIZE-1:0]         operator_length,
  input  logic [BS_W-1:0]              bit_serial,
  input  logic [BS_W-1:0]              bit_serial_wait,
  input  logic [N_BANKS*WORD_SIZE-1:0] q_a,
  input  logic [N_BANKS*WORD_SIZE-1:0] q_b,
  output logic [N_BANKS*WORD_SIZE-1:0] pe_data,
  output logic                         pe_valid,
  output logic [BANK_W-1:0]            rot_state,
  output logic [ADDR_SIZE-1:0]         pe_count
);
  localparam logic [BANK_W:0]   NB   = (BANK_W+1)'(N_BANKS);
  localparam logic [BANK_W-1:0] LAST = BANK_W'(N_BANKS-1);

  typedef struct packed {
    logic              vld;
    logic              sel;
    logic [BANK_W-1:0] rot;
  } rd_tag_t;

  rd_tag_t tag_in, tail;
  rd_tag_t pipe_q [RD_LATENCY-1:0];

  logic [BANK_W-1:0]    rot_q, rot_d;
  logic [ADDR_SIZE-1:0] cnt_q, cnt_d;
  logic [N_BANKS*WORD_SIZE-1:0] data_q, q_sel;
  logic                 valid_q;
  logic [N_BANKS-1:0][WORD_SIZE-1:0] lanes;

  // Rotation is frozen into the tag at issue so later row_adv cannot disturb
  // reads already in flight.
  always_comb begin
    tag_in.vld = rd_en & (rd_addr < operator_length) & (bit_serial == bit_serial_wait);
    tag_in.sel = buf_sel;
    tag_in.rot = (kernel_size == 2'd3) ? rot_q : '0;
  end

  assign tail  = pipe_q[RD_LATENCY-1];
  assign q_sel = tail.sel ? q_b : q_a;

  for (genvar j = 0; j < N_BANKS; j++) begin : g_lane
    ibuf_pe_lane_sel #(
      .WORD_SIZE(WORD_SIZE), .N_BANKS(N_BANKS), .BANK_W(BANK_W), .LANE(j)
    ) u_sel (
      .q_i(q_sel), .rot_i(tail.rot), .word_o(lanes[j])
    );
  end

  always_comb begin
    rot_d = rot_q;
    if (start)        rot_d = ({1'b0, start_bank} >= NB) ? '0 : start_bank;
    else if (row_adv) rot_d = (rot_q == LAST) ? '0 : rot_q + 1'b1;
  end

  // start clears even when a beat lands on the same edge; in-flight beats
  // that arrive afterwards count against the new tile.
  always_comb begin
    cnt_d = cnt_q;
    if (start)                      cnt_d = '0;
    else if (tail.vld && ~&cnt_q)   cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LATENCY; i++) pipe_q[i] <= '0;
      rot_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      pipe_q[0] <= tag_in;
      for (int i = 1; i < RD_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
      rot_q   <= rot_d;
      cnt_q   <= cnt_d;
      valid_q <= tail.vld;
      if (tail.vld) data_q <= lanes;
    end
  end

  assign pe_data   = data_q;
  assign pe_valid  = valid_q;
  assign rot_state = rot_q;
  assign pe_count  = cnt_q;
endmodule
